gcd_engine: RTL and testbench
=============================

# gcd_engine

Parametrised greatest-common-divisor (HCF) engine: the multi-width, handshaked successor of the fixed 4-bit subtract-only HCF datapath. It accepts an operand pair on a start pulse and computes the GCD in either of two modes: repeated subtraction or binary (Stein). It reports completion with a one-cycle done pulse, a held result and an iteration count. It is used as a shared arithmetic slave under a controller FSM.

## Interface
- WIDTH, 8, operand and result width (≥2)
- STEP_W, 16, width of the iteration counter (≥1)
- clk  in  1  clock, rising edge active
- clear  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- mode  in  1  0 = subtraction, 1 = binary (Stein); sampled with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- hcf  out  WIDTH  result; held until the next completion
- steps  out  STEP_W  iteration count of the current or last operation

## Operation
- States: IDLE, CALC, DONE. Internal registers: A, B (WIDTH), shift count k (clog2(WIDTH)+1 bits), latched mode m.
- IDLE: if start=1, then A←a, B←b, m←mode, k←0, steps←0, go to CALC. Otherwise stay in IDLE.
- CALC evaluates one check per clock, in this priority order:
  - A==0: hcf←B<<k, go to DONE.
  - B==0: hcf←A<<k, go to DONE.
  - A==B: hcf←A<<k, go to DONE.
  - m=0, A>B: A←A−B, steps++.
  - m=0, A<B: B←B−A, steps++.
  - m=1, A and B both even: A←A>>1, B←B>>1, k++, steps++.
  - m=1, only A even: A←A>>1, steps++.
  - m=1, only B even: B←B>>1, steps++.
  - m=1, both odd, A>B: A←(A−B)>>1, steps++.
  - m=1, both odd, A<B: B←(B−A)>>1, steps++.
- In mode 0, k stays 0. A result ≤ max(a,b) always fits in WIDTH bits; no overflow path exists.
- steps saturates at 2^STEP_W−1 and never wraps. A saturated count does not affect the result.
- DONE: done=1 for exactly this one cycle. Go unconditionally to IDLE. start is ignored in DONE.
- start while busy=1 (CALC or DONE) is ignored. a, b and mode may change freely after acceptance.
- gcd(0,0)=0. gcd(x,0)=gcd(0,x)=x.
- clear (any state, any time): state←IDLE; A, B, k, m, hcf, steps←0; done←0. Any in-flight operation is discarded with no done pulse.

## Timing
- Reset values: busy=0, done=0, hcf=0, steps=0.
- Acceptance edge: the rising edge at which IDLE samples start=1. busy rises after this edge.
- Latency: done is high in the cycle after edge acceptance+steps+1, where steps is the final iteration count. Minimum latency is 1 edge, for terminating operands.
- hcf and the final steps value update on the same edge that raises done. Both stay stable until the next acceptance edge: steps clears to 0 there, hcf is held until the next completion.
- busy falls on the edge after done. start can be accepted on the first edge at which busy=0, so back-to-back operations cost 1 idle cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- mode=0, a=12, b=18 → steps=2, hcf=6, done pulse 3 edges after acceptance, busy low 1 edge later.
- mode=1, a=48, b=18 → intermediate (24,9,k=1), (12,9), (6,9), (3,9), (3,3); steps=5, hcf=6, done 6 edges after acceptance.
- Zero operands, either mode: (0,0) → hcf=0; (0,200) → hcf=200; (200,0) → hcf=200. Each has steps=0 and done 1 edge after acceptance.
- mode=0, a=255, b=1 → steps=254, hcf=1. Rerun with STEP_W=4 → steps saturates at 15, hcf=1.
- Assert start with new operands every cycle during an operation → all ignored, result unchanged. Assert start on the first cycle with busy=0 → second operation accepted; exactly one done pulse per accepted operation.
- Assert clear mid-CALC, during a mode-1 run on (48,18) → all outputs return to reset values immediately with no done pulse. A fresh start of mode=0 on (7,5) then gives hcf=1, steps=4.

Source files
------------

// File: rtl/gcd_engine.sv
// gcd_engine: start/done GCD slave with a subtraction mode and a binary (Stein) mode.
// Ports: clk, clear (async reset), start/a/b/mode in; busy/done/hcf/steps out.
//
// Port summary
//   clk    in   rising-edge clock
//   clear  in   asynchronous active-high reset
//   start  in   request, sampled only while idle
//   a, b   in   operands, sampled with start
//   mode   in   0 = repeated subtraction, 1 = binary (Stein)
//   busy   out  high while an operation is in flight or completing
//   done   out  one-cycle completion pulse
//   hcf    out  result, held until the next completion
//   steps  out  iteration count of the current or last operation
module gcd_engine #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hcf,
  output logic [STEP_W-1:0] steps
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [KW-1:0]      k_q, k_d;
  logic               m_q, m_d;
  logic [WIDTH-1:0]   hcf_q, hcf_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_minus_b;
  logic [WIDTH-1:0]   b_minus_a;
  logic [STEP_W-1:0]  steps_inc;
  logic               a_zero, b_zero, a_eq_b, a_gt_b;
  logic               a_even, b_even;

  assign a_minus_b = a_q - b_q;
  assign b_minus_a = b_q - a_q;
  assign a_zero    = (a_q == '0);
  assign b_zero    = (b_q == '0);
  assign a_eq_b    = (a_q == b_q);
  assign a_gt_b    = (a_q > b_q);
  assign a_even    = ~a_q[0];
  assign b_even    = ~b_q[0];

  // Saturating count: a pinned counter never affects the datapath.
  assign steps_inc = (&steps_q) ? steps_q : steps_q + STEP_W'(1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      m_q     <= 1'b0;
      hcf_q   <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      m_q     <= m_d;
      hcf_q   <= hcf_d;
      steps_q <= steps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    m_d     = m_q;
    hcf_d   = hcf_q;
    steps_d = steps_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = mode;
          k_d     = '0;
          steps_d = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        // Termination checks take priority over any reduction step.
        if (a_zero) begin
          hcf_d   = b_q << k_q;
          state_d = S_DONE;
        end else if (b_zero || a_eq_b) begin
          hcf_d   = a_q << k_q;
          state_d = S_DONE;
        end else if (!m_q) begin
          steps_d = steps_inc;
          if (a_gt_b) begin
            a_d = a_minus_b;
          end else begin
            b_d = b_minus_a;
          end
        end else begin
          steps_d = steps_inc;
          if (a_even && b_even) begin
            // Common factor of two is folded back in via k.
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + KW'(1);
          end else if (a_even) begin
            a_d = a_q >> 1;
          end else if (b_even) begin
            b_d = b_q >> 1;
          end else if (a_gt_b) begin
            // odd - odd is even, so the halving is exact.
            a_d = a_minus_b >> 1;
          end else begin
            b_d = b_minus_a >> 1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy and done are registered copies of the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hcf   = hcf_q;
  assign steps = steps_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized and directed bench for gcd_engine
// against an arithmetic reference model; a STEP_W=4 copy covers saturation.
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        mode;
  logic        busy;
  logic        done;
  logic [7:0]  hcf;
  logic [15:0] steps;
  logic        busy4;
  logic        done4;
  logic [7:0]  hcf4;
  logic [3:0]  steps4;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  gcd_engine #(.WIDTH(8), .STEP_W(16)) dut (
    .clk(clk), .clear(clear), .start(start),
    .a(a), .b(b), .mode(mode),
    .busy(busy), .done(done), .hcf(hcf), .steps(steps)
  );

  gcd_engine #(.WIDTH(8), .STEP_W(4)) dut4 (
    .clk(clk), .clear(clear), .start(start),
    .a(a), .b(b), .mode(mode),
    .busy(busy4), .done(done4), .hcf(hcf4), .steps(steps4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  function automatic int unsigned euclid(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic void ref_model(input int unsigned x, input int unsigned y,
                                    input bit m, output int unsigned g,
                                    output int unsigned n);
    int unsigned k;
    k = 0;
    n = 0;
    g = 0;
    for (int guard = 0; guard < 100000; guard++) begin
      if (x == 0) begin g = y * (2 ** k); break; end
      if (y == 0 || x == y) begin g = x * (2 ** k); break; end
      n++;
      if (!m) begin
        if (x > y) x = x - y; else y = y - x;
      end else if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2; y = y / 2; k++;
      end else if (x % 2 == 0) begin
        x = x / 2;
      end else if (y % 2 == 0) begin
        y = y / 2;
      end else if (x > y) begin
        x = (x - y) / 2;
      end else begin
        y = (y - x) / 2;
      end
    end
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) lat = -1;
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                        output logic [7:0] oh, output logic [15:0] os, output int lat);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; mode = im;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
    wait_done(lat);
    oh = hcf;
    os = steps;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, hcf, steps} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b hcf=%0d steps=%0d, want all 0", busy, done, hcf, steps);
    end
    clear = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] h; logic [15:0] s; int lat;
    run_op(8'd12, 8'd18, 1'b0, h, s, lat);
    vectors++;
    if (h !== 8'd6 || s !== 16'd2 || lat !== 3) begin
      miscompares++;
      $display("FAIL sub_12_18: hcf=%0d steps=%0d lat=%0d, want 6 2 3", h, s, lat);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_done: busy=%b, want 1", busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hcf !== 8'd6 || steps !== 16'd2) begin
      miscompares++;
      $display("FAIL after_done: busy=%b done=%b hcf=%0d steps=%0d, want 0 0 6 2", busy, done, hcf, steps);
    end
    run_op(8'd48, 8'd18, 1'b1, h, s, lat);
    vectors++;
    if (h !== 8'd6 || s !== 16'd5 || lat !== 6) begin
      miscompares++;
      $display("FAIL stein_48_18: hcf=%0d steps=%0d lat=%0d, want 6 5 6", h, s, lat);
    end
  endtask

  task automatic test_zero();
    logic [7:0] h; logic [15:0] s; int lat;
    logic [7:0] za [3];
    logic [7:0] zb [3];
    logic [7:0] zh [3];
    za = '{8'd0, 8'd0,   8'd200};
    zb = '{8'd0, 8'd200, 8'd0};
    zh = '{8'd0, 8'd200, 8'd200};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        run_op(za[i], zb[i], 1'(m), h, s, lat);
        vectors++;
        if (h !== zh[i] || s !== 16'd0 || lat !== 1) begin
          miscompares++;
          $display("FAIL zero m=%0d (%0d,%0d): hcf=%0d steps=%0d lat=%0d, want %0d 0 1",
                   m, za[i], zb[i], h, s, lat, zh[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] h; logic [15:0] s; int lat;
    run_op(8'd255, 8'd1, 1'b0, h, s, lat);
    vectors++;
    if (h !== 8'd1 || s !== 16'd254 || lat !== 255) begin
      miscompares++;
      $display("FAIL sub_255_1: hcf=%0d steps=%0d lat=%0d, want 1 254 255", h, s, lat);
    end
    vectors++;
    if (hcf4 !== 8'd1 || steps4 !== 4'd15 || done4 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat4: hcf=%0d steps=%0d done=%b, want 1 15 1", hcf4, steps4, done4);
    end
  endtask

  task automatic test_random();
    logic [7:0] h; logic [15:0] s; int lat;
    logic [7:0] ra, rb; logic rm;
    int unsigned g, n, n4;
    for (int i = 0; i < 40; i++) begin
      ra = (i % 8 == 0) ? 8'd0 : 8'($urandom);
      rb = (i % 11 == 3) ? 8'd0 : 8'($urandom);
      rm = 1'($urandom_range(0, 1));
      ref_model(ra, rb, rm, g, n);
      n4 = (n > 15) ? 15 : n;
      run_op(ra, rb, rm, h, s, lat);
      vectors++;
      if (h !== 8'(euclid(ra, rb)) || h !== 8'(g) || s !== 16'(n) || lat !== int'(n) + 1) begin
        miscompares++;
        $display("FAIL rand m=%0d (%0d,%0d): hcf=%0d steps=%0d lat=%0d, want %0d %0d %0d",
                 rm, ra, rb, h, s, lat, g, n, n + 1);
      end
      vectors++;
      if (steps4 !== 4'(n4) || hcf4 !== 8'(g)) begin
        miscompares++;
        $display("FAIL rand4 (%0d,%0d): hcf=%0d steps=%0d, want %0d %0d", ra, rb, hcf4, steps4, g, n4);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat; int c0;
    @(posedge clk);
    c0 = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 8'd48; b = 8'd18; mode = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 1000) begin
      @(negedge clk);
      if (done) break;
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
      @(posedge clk);
      lat++;
    end
    vectors++;
    if (hcf !== 8'd6 || steps !== 16'd5 || lat !== 6) begin
      miscompares++;
      $display("FAIL ignore: hcf=%0d steps=%0d lat=%0d, want 6 5 6", hcf, steps, lat);
    end
    a = 8'd12; b = 8'd18; mode = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hcf !== 8'd6) begin
      miscompares++;
      $display("FAIL idle_gap: busy=%b done=%b hcf=%0d, want 0 0 6", busy, done, hcf);
    end
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || steps !== 16'd0 || hcf !== 8'd6) begin
      miscompares++;
      $display("FAIL reaccept: busy=%b steps=%0d hcf=%0d, want 1 0 6", busy, steps, hcf);
    end
    wait_done(lat);
    vectors++;
    if (hcf !== 8'd6 || steps !== 16'd2 || lat !== 3) begin
      miscompares++;
      $display("FAIL second_op: hcf=%0d steps=%0d lat=%0d, want 6 2 3", hcf, steps, lat);
    end
    @(posedge clk);
    vectors++;
    if (done_cnt - c0 !== 2) begin
      miscompares++;
      $display("FAIL done_count: got %0d pulses, want 2", done_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] h; logic [15:0] s; int lat; int c0;
    int unsigned g, n;
    logic [7:0] ra, rb;
    @(posedge clk);
    c0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(1, 255));
      rb = 8'($urandom_range(1, 255));
      ref_model(ra, rb, 1'b1, g, n);
      run_op(ra, rb, 1'b1, h, s, lat);
      vectors++;
      if (h !== 8'(g) || s !== 16'(n) || lat !== int'(n) + 1) begin
        miscompares++;
        $display("FAIL b2b (%0d,%0d): hcf=%0d steps=%0d lat=%0d, want %0d %0d %0d",
                 ra, rb, h, s, lat, g, n, n + 1);
      end
    end
    @(posedge clk);
    vectors++;
    if (done_cnt - c0 !== 6) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d pulses, want 6", done_cnt - c0);
    end
  endtask

  task automatic test_clear();
    logic [7:0] h; logic [15:0] s; int lat; int c0;
    @(negedge clk);
    start = 1'b1; a = 8'd48; b = 8'd18; mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    c0 = done_cnt;
    clear = 1'b1;
    #1;
    vectors++;
    if ({busy, done, hcf, steps} !== 26'd0) begin
      miscompares++;
      $display("FAIL clear: busy=%b done=%b hcf=%0d steps=%0d, want all 0", busy, done, hcf, steps);
    end
    @(negedge clk);
    clear = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    vectors++;
    if (done_cnt !== c0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_nodone: pulses=%0d busy=%b, want 0 0", done_cnt - c0, busy);
    end
    run_op(8'd7, 8'd5, 1'b0, h, s, lat);
    vectors++;
    if (h !== 8'd1 || s !== 16'd4 || lat !== 5) begin
      miscompares++;
      $display("FAIL after_clear: hcf=%0d steps=%0d lat=%0d, want 1 4 5", h, s, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_saturate();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_clear();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
